// File: rtl/voice.sv
// ---------------------------------------------------------------------------
// voice
//   Single-voice sample playback address generator. A rising edge on
//   trigger captures a start and an inclusive end address. The block then
//   steps addr from start to end, one address every RATE_DIV clocks, and
//   parks on the end address. One instance per voice; addr drives the read
//   address of the sample memory.
//
// Parameters
//   ADDR_W    width of sstart, send and addr
//   RATE_DIV  clocks per address step (>= 1; 1 = one step per clock)
//
// Ports
//   clk      in   system clock, rising-edge active
//   rst_n    in   asynchronous active-low reset
//   sstart   in   sample start address, captured on a trigger rise
//   send     in   sample end address (inclusive), captured on a trigger rise
//   trigger  in   start/retrigger request, acted on at its rising edge
//   addr     out  current sample read address (registered)
//   playing  out  high while stepping toward the end address (registered)
// ---------------------------------------------------------------------------
module voice #(
  parameter int ADDR_W   = 16,
  parameter int RATE_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sstart,
  input  logic [ADDR_W-1:0] send,
  input  logic              trigger,
  output logic [ADDR_W-1:0] addr,
  output logic              playing
);

  // Prescaler is kept at least one bit wide so RATE_DIV=1 still elaborates;
  // in that case it simply stays at zero and every edge is a step.
  localparam int              PW        = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(RATE_DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  logic              trig_q;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W-1:0] end_q,   end_d;
  logic [PW-1:0]     presc_q, presc_d;

  logic              rise;
  logic [ADDR_W-1:0] addrInc;

  assign rise    = trigger & ~trig_q;
  assign addrInc = addr_q + ADDR_W'(1);

  // The start address needs no separate register: it is loaded straight
  // into addr at the rise and never referenced again.
  //
  // A rise takes priority over stepping, so a retrigger on the same edge
  // that the end address would have been reached restarts playback.
  // Stepping stops exactly when addr reaches end_q, so addr cannot wrap.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    presc_d = presc_q;
    if (rise) begin
      end_d   = send;
      addr_d  = sstart;
      presc_d = '0;
      state_d = (sstart < send) ? PLAY : IDLE;
    end else if (state_q == PLAY) begin
      if (presc_q == PRESC_MAX) begin
        addr_d  = addrInc;
        presc_d = '0;
        if (addrInc == end_q) begin
          state_d = IDLE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Trigger history resets to 0, so a trigger already high when reset is
  // released is seen as a rise on the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q  <= 1'b0;
      state_q <= IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      presc_q <= '0;
    end else begin
      trig_q  <= trigger;
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      presc_q <= presc_d;
    end
  end

  assign addr    = addr_q;
  assign playing = (state_q == PLAY);

endmodule

// File: tb/tb_voice.sv
// ---------------------------------------------------------------------------
// tb_voice
//   Scoreboard bench for voice. Two instances share clock, reset and the
//   address inputs: dut1 steps every clock, dut4 every fourth clock; each
//   has its own trigger. Stimulus pushes the hand-computed expectation for
//   the coming edge into a queue; a monitor pops and compares entries once
//   their due time is reached (each falling edge, or on demand for checks
//   that must happen without a clock edge).
// ---------------------------------------------------------------------------
module tb_voice;

  localparam int  ADDR_W = 16;
  localparam time PERIOD = 10;

  typedef struct {
    string             name;
    bit                sel;
    logic [ADDR_W-1:0] expAddr;
    logic              expPlaying;
    time               due;
  } expect_t;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] sstart;
  logic [ADDR_W-1:0] send;
  logic              trig1;
  logic              trig4;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr4;
  logic              playing1;
  logic              playing4;

  expect_t sb[$];
  int      checks   = 0;
  int      failures = 0;
  event    checkNow;

  voice #(.ADDR_W(ADDR_W), .RATE_DIV(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sstart  (sstart),
    .send    (send),
    .trigger (trig1),
    .addr    (addr1),
    .playing (playing1)
  );

  voice #(.ADDR_W(ADDR_W), .RATE_DIV(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sstart  (sstart),
    .send    (send),
    .trigger (trig4),
    .addr    (addr4),
    .playing (playing4)
  );

  initial begin
    clk = 1'b0;
    forever #(PERIOD / 2) clk = ~clk;
  end

  // Compare one scoreboard entry against the selected instance.
  task automatic checkOutput(input expect_t e);
    logic [ADDR_W-1:0] actAddr;
    logic              actPlaying;
    actAddr    = e.sel ? addr4 : addr1;
    actPlaying = e.sel ? playing4 : playing1;
    checks++;
    if (actAddr !== e.expAddr || actPlaying !== e.expPlaying) begin
      failures++;
      $display("[TB] FAIL %s (dut%0d) @%0t: addr=%h playing=%b, expected addr=%h playing=%b",
               e.name, e.sel ? 4 : 1, $time, actAddr, actPlaying, e.expAddr, e.expPlaying);
    end
  endtask

  // Monitor: drain every entry whose due time has arrived.
  initial begin
    forever begin
      @(negedge clk or checkNow);
      while (sb.size() > 0 && sb[0].due <= $time) begin
        checkOutput(sb.pop_front());
      end
    end
  end

  // Queue the expectation for the next rising edge, then advance to the
  // following falling edge where it is checked. Called just after a
  // falling edge, with inputs already set for the coming edge.
  task automatic applyStimulus(input bit sel, input logic [ADDR_W-1:0] expAddr,
                               input logic expPlaying, input string name);
    expect_t e;
    e.name       = name;
    e.sel        = sel;
    e.expAddr    = expAddr;
    e.expPlaying = expPlaying;
    e.due        = $time + PERIOD;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Queue an immediate (clockless) check of one instance.
  task automatic pushNow(input bit sel, input logic [ADDR_W-1:0] expAddr,
                         input logic expPlaying, input string name);
    expect_t e;
    e.name       = name;
    e.sel        = sel;
    e.expAddr    = expAddr;
    e.expPlaying = expPlaying;
    e.due        = $time;
    sb.push_back(e);
  endtask

  initial begin
    rst_n  = 1'b0;
    sstart = '0;
    send   = '0;
    trig1  = 1'b0;
    trig4  = 1'b0;

    // Reset values, checked while reset is held.
    repeat (2) @(negedge clk);
    #2;
    pushNow(1'b0, 16'd0, 1'b0, "resetDut1");
    pushNow(1'b1, 16'd0, 1'b0, "resetDut4");
    ->checkNow;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 16'd0, 1'b0, "idleAfterReset");

    // Basic run 0..100, trigger high for two edges.
    sstart = 16'd0;
    send   = 16'd100;
    trig1  = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b1, "runStart");
    applyStimulus(1'b0, 16'd1, 1'b1, "runTrigHeld");
    trig1 = 1'b0;
    for (int k = 2; k <= 100; k++)
      applyStimulus(1'b0, ADDR_W'(k), (k != 100), "runStep");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'd100, 1'b0, "runHoldEnd");

    // Retrigger at addr=40.
    trig1 = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b1, "rerunStart");
    trig1 = 1'b0;
    for (int k = 1; k <= 40; k++) applyStimulus(1'b0, ADDR_W'(k), 1'b1, "rerunStep");
    trig1 = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b1, "retrigger");
    trig1 = 1'b0;
    for (int k = 1; k <= 100; k++)
      applyStimulus(1'b0, ADDR_W'(k), (k != 100), "afterRetrigger");

    // Degenerate ranges.
    sstart = 16'd50;
    send   = 16'd50;
    trig1  = 1'b1;
    applyStimulus(1'b0, 16'd50, 1'b0, "equalRange");
    trig1 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd50, 1'b0, "equalHold");
    sstart = 16'd60;
    send   = 16'd20;
    trig1  = 1'b1;
    applyStimulus(1'b0, 16'd60, 1'b0, "reversedRange");
    trig1 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd60, 1'b0, "reversedHold");

    // Top of range with inputs changed during playback.
    sstart = 16'hFFF0;
    send   = 16'hFFFF;
    trig1  = 1'b1;
    applyStimulus(1'b0, 16'hFFF0, 1'b1, "topStart");
    trig1  = 1'b0;
    sstart = 16'd0;
    send   = 16'd0;
    for (int k = 1; k <= 15; k++)
      applyStimulus(1'b0, 16'hFFF0 + ADDR_W'(k), (k != 15), "topStep");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'hFFFF, 1'b0, "topNoWrap");

    // RATE_DIV=4, 10..12.
    sstart = 16'd10;
    send   = 16'd12;
    trig4  = 1'b1;
    applyStimulus(1'b1, 16'd10, 1'b1, "div4Start");
    trig4 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd10, 1'b1, "div4Addr10");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd11, 1'b1, "div4Addr11");
    applyStimulus(1'b1, 16'd12, 1'b0, "div4End");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'd12, 1'b0, "div4Hold");

    // Async reset mid-run, no clock edge involved, no resumption after.
    sstart = 16'd100;
    send   = 16'd200;
    trig4  = 1'b1;
    applyStimulus(1'b1, 16'd100, 1'b1, "div4Restart");
    trig4 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd100, 1'b1, "div4Run100");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'd101, 1'b1, "div4Run101");
    #2;
    rst_n = 1'b0;
    #1;
    pushNow(1'b1, 16'd0, 1'b0, "asyncResetDut4");
    pushNow(1'b0, 16'd0, 1'b0, "asyncResetDut1");
    ->checkNow;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd0, 1'b0, "noResume");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice.md
Name: voice

Overview:
- Single-voice sample playback address generator.
- On a trigger rising edge it captures a start and an end address, then steps `addr` from start to end, one address per rate tick, and stops holding the end address.
- Drives the read address of a sample memory in the synth datapath; one instance per voice.

Parameters:
- ADDR_W, 16, width of `sstart`, `send` and `addr`.
- RATE_DIV, 1, clock cycles per address step; must be ≥1; 1 means one step every clock.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- sstart  input  ADDR_W  sample start address, captured on trigger.
- send  input  ADDR_W  sample end address (inclusive), captured on trigger.
- trigger  input  1  start/retrigger request; level input, acted on at its rising edge.
- addr  output  ADDR_W  current sample read address, registered.
- playing  output  1  high while stepping toward the end address.

Behaviour:
- Reset (rst_n low, asynchronous):
  - addr=0, playing=0.
  - Latched start/end = 0, prescaler = 0.
  - Trigger history register = 0; trigger high at reset release counts as a rising edge on the first clock.
- Trigger detect:
  - trigger is registered each clock (trig_d).
  - A rise is trigger=1 and trig_d=0, sampled at a clk edge.
  - Holding trigger high causes no further rises.
- States:
  - IDLE (playing=0): addr holds its value.
  - PLAY (playing=1).
- On a rise (any state, including mid-playback = retrigger), at the same edge:
  - start_q<=sstart, end_q<=send, addr<=sstart, prescaler<=0.
  - If sstart < send: go to PLAY, playing<=1.
  - Otherwise (sstart ≥ send): stay/go IDLE, playing<=0, addr=sstart.
- In PLAY, without a rise:
  - Prescaler counts 0..RATE_DIV-1.
  - When it reaches RATE_DIV-1 (every edge if RATE_DIV=1), addr<=addr+1 and prescaler<=0.
  - If addr+1 == end_q, playing<=0 at that same edge and state returns to IDLE.
- Step timing:
  - With RATE_DIV=1, the first increment occurs one clock after the rise edge.
  - addr covers sstart..send inclusive.
  - playing is high for (send−sstart)·RATE_DIV cycles.
- Arithmetic:
  - Unsigned ADDR_W-bit compares.
  - addr never wraps, because stepping stops at end_q ≤ 2^ADDR_W−1.
- Input isolation: changes to sstart/send after a rise have no effect until the next rise.
- Simultaneous rise and end-reached on the same edge: the rise wins and playback restarts.
- Reset mid-playback: immediate return to reset values; no resumption after release.

Test Plan:
- Reset: rst_n low with trigger=0 -> addr=0, playing=0; release; 10 clocks -> unchanged.
- Basic run, RATE_DIV=1, sstart=0, send=100, trigger high for 2 edges then low:
  - After first edge: addr=0, playing=1.
  - Each following edge: addr increments.
  - addr=100 and playing=0 exactly 100 edges after the trigger edge.
  - addr holds 100 thereafter; trigger held high does not restart.
- Retrigger mid-run with sstart=0, send=100 again:
  - Second rise when addr=40 -> addr=0 at that edge, playing stays 1.
  - Reaches 100 after 100 more edges.
- Degenerate ranges:
  - sstart=50, send=50 -> addr=50, playing=0 after the rise edge, no stepping.
  - sstart=60, send=20 -> addr=60, playing=0.
- Input isolation and top of range, sstart=0xFFF0, send=0xFFFF:
  - Change sstart/send to 0 during playback -> playback unaffected.
  - Ends at 0xFFFF, no wrap to 0.
- RATE_DIV=4, sstart=10, send=12:
  - addr=10 for 4 edges, 11 for 4 edges, then 12 with playing=0.
  - Total playing-high time = 8 cycles.
  - Async reset asserted mid-run -> addr=0, playing=0 immediately, without a clock.
